trigger_bus_arbiter: RTL

Round-robin arbiter and load sequencer that shares the 10-bit trigger register bank's input bus between several requesters. Each requester presents a 10-bit pattern. The arbiter grants one requester at a time, drives the pattern onto the trigger bus with a single-cycle load strobe, holds it for a programmable settle window, then acknowledges. It sits directly in front of the trigger bank and is its only writer.

---
 rtl/trigger_bus_arbiter_if.sv | 26 ++
 rtl/trigger_bus_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/trigger_bus_arbiter_if.sv
// Trigger-bus handshake bundle: requester levels/patterns in, load strobe,
// completion pulses and grant status out.
interface trigger_bus_arbiter_if #(
  parameter int WIDTH = 10,
  parameter int N_REQ = 4
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       trig_d;
  logic                   trig_en;
  logic                   busy;
  logic [OW-1:0]          owner;

  modport master (
    output req, req_data,
    input  ack, trig_d, trig_en, busy, owner
  );

  modport slave (
    input  req, req_data,
    output ack, trig_d, trig_en, busy, owner
  );
endinterface

// File: rtl/trigger_bus_arbiter.sv
// Round-robin arbiter and load sequencer; sole writer of the trigger register bank.
//   state  | meaning
//   IDLE   | waiting for a request, pattern held on trig_d
//   LOAD   | grant latched, trig_en strobe high
//   HOLD   | settle window, counter runs down to terminal count
//   ACK    | ack[owner] pulse, pointer advances to owner
module trigger_bus_arbiter #(
  parameter int WIDTH       = 10,
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  trigger_bus_arbiter_if.slave  bus
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = OW + 1;
  localparam logic [3:0] HOLD_LD = 4'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_ACK} state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [OW-1:0]    last_q;
  logic [OW-1:0]    owner_q;
  logic [WIDTH-1:0] trig_d_q;
  logic             trig_en_q;
  logic [N_REQ-1:0] ack_q;
  logic             busy_q;

  logic             found_d;
  logic [OW-1:0]    winner_d;

  // First active request searching last+1, last+2, ... modulo N_REQ.
  always_comb begin
    logic [SW-1:0] s;
    logic [OW-1:0] sel;
    found_d  = 1'b0;
    winner_d = '0;
    s        = '0;
    sel      = '0;
    for (int j = 1; j <= N_REQ; j++) begin
      s = {1'b0, last_q} + SW'(j);
      if (s >= SW'(N_REQ)) s = s - SW'(N_REQ);
      sel = s[OW-1:0];
      if (!found_d && bus.req[sel]) begin
        found_d  = 1'b1;
        winner_d = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= OW'(N_REQ - 1);
      owner_q   <= '0;
      trig_d_q  <= '0;
      trig_en_q <= 1'b0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      trig_en_q <= 1'b0;
      ack_q     <= '0;
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            owner_q   <= winner_d;
            trig_d_q  <= bus.req_data[int'(winner_d)*WIDTH +: WIDTH];
            trig_en_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (HOLD_CYCLES == 0) begin
            ack_q[owner_q] <= 1'b1;
            state_q        <= S_ACK;
          end else begin
            cnt_q   <= HOLD_LD;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (cnt_q == 4'd0) begin
            ack_q[owner_q] <= 1'b1;
            state_q        <= S_ACK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: begin
          last_q  <= owner_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ack     = ack_q;
  assign bus.trig_d  = trig_d_q;
  assign bus.trig_en = trig_en_q;
  assign bus.busy    = busy_q;
  assign bus.owner   = owner_q;
endmodule
